// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, pipeline constants, EX payload.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    // MIPS instruction field bit positions
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int SH_HI  = 10;
    localparam int SH_LO  = 6;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    localparam int          CTRL_W_DFLT = 16;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic [31:0] PC_STEP     = 32'd4;

    // Data payload carried from ID into EX (control bundle kept separate
    // because its width is a module parameter)
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] shamt;
        logic [31:0] imm;
        logic [31:0] br_off;
        logic [31:0] br_tgt;
    } ex_data_t;

endpackage

// File: rtl/extend.sv
// Generic zero/sign extender from IN_W to OUT_W bits.
// Latency: combinational.
// Backpressure: none.
// Ports: in_i (IN_W) value, sext_i 1 = sign-extend, out_o (OUT_W) extended value.
module extend #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  in_i,
    input  logic             sext_i,
    output logic [OUT_W-1:0] out_o
);

    assign out_o = {{(OUT_W-IN_W){sext_i & in_i[IN_W-1]}}, in_i};

endmodule

// File: rtl/imm_gen.sv
// Immediate generator: extended shamt, imm16, branch offset and branch target.
// Latency: combinational.
// Backpressure: none.
// Ports: instr_i instruction word, pc_i its PC, sext_i 1 = sign-extend imm16;
//        shamt32_o, imm32_o, br_off32_o, br_tgt32_o extended results.
module imm_gen
    import cpu_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        sext_i,
    output logic [31:0] shamt32_o,
    output logic [31:0] imm32_o,
    output logic [31:0] br_off32_o,
    output logic [31:0] br_tgt32_o
);

    // Opcode and register fields are not needed for immediate generation
    logic unused_instr_hi;
    assign unused_instr_hi = ^instr_i[31:16];

    extend #(.IN_W(5), .OUT_W(32)) u_ext_shamt (
        .in_i   (instr_i[SH_HI:SH_LO]),
        .sext_i (1'b0),
        .out_o  (shamt32_o)
    );

    extend #(.IN_W(16), .OUT_W(32)) u_ext_imm (
        .in_i   (instr_i[IMM_HI:IMM_LO]),
        .sext_i (sext_i),
        .out_o  (imm32_o)
    );

    // Branch offsets are always signed word offsets, independent of sext_i
    extend #(.IN_W(18), .OUT_W(32)) u_ext_br (
        .in_i   ({instr_i[IMM_HI:IMM_LO], 2'b00}),
        .sext_i (1'b1),
        .out_o  (br_off32_o)
    );

    // Wraps modulo 2^32 by construction
    assign br_tgt32_o = pc_i + PC_STEP + br_off32_o;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with pre-extended immediates, valid bit and bubble counter.
// Latency: 1 cycle from ID inputs to EX outputs; outputs are purely registered.
// Backpressure: stall holds all EX state; flush (wins over stall) inserts a bubble.
// Ports: clk, rst_n (async active-low); id_* ID-stage instruction, PC, sext, ctrl;
//        stall, flush; ex_* registered EX fields; bubble_cnt saturating bubble count.
module id_ex_reg
    import cpu_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DFLT,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic [31:0]       id_pc,
    input  logic              id_sext,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [31:0]       ex_shamt,
    output logic [31:0]       ex_imm,
    output logic [31:0]       ex_br_off,
    output logic [31:0]       ex_br_tgt,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [31:0] shamt32, imm32, br_off32, br_tgt32;

    imm_gen u_imm_gen (
        .instr_i    (id_instr),
        .pc_i       (id_pc),
        .sext_i     (id_sext),
        .shamt32_o  (shamt32),
        .imm32_o    (imm32),
        .br_off32_o (br_off32),
        .br_tgt32_o (br_tgt32)
    );

    ex_data_t          data_q, data_d, data_ld;
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;

    always_comb begin
        data_ld        = '0;
        data_ld.pc     = id_pc;
        data_ld.rs     = id_instr[RS_HI:RS_LO];
        data_ld.rt     = id_instr[RT_HI:RT_LO];
        data_ld.rd     = id_instr[RD_HI:RD_LO];
        data_ld.shamt  = shamt32;
        data_ld.imm    = imm32;
        data_ld.br_off = br_off32;
        data_ld.br_tgt = br_tgt32;
    end

    // Saturate rather than wrap so a long-running counter never reads low
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        if (flush || (!stall && !id_valid)) begin
            // Bubble: flush discards even a stalled instruction
            data_d  = '0;
            valid_d = 1'b0;
            ctrl_d  = '0;
            cnt_d   = cnt_inc;
        end else if (!stall) begin
            data_d  = data_ld;
            valid_d = 1'b1;
            ctrl_d  = id_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_pc      = data_q.pc;
    assign ex_rs      = data_q.rs;
    assign ex_rt      = data_q.rt;
    assign ex_rd      = data_q.rd;
    assign ex_shamt   = data_q.shamt;
    assign ex_imm     = data_q.imm;
    assign ex_br_off  = data_q.br_off;
    assign ex_br_tgt  = data_q.br_tgt;
    assign ex_ctrl    = ctrl_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_sext;
    logic [15:0] id_ctrl;
    logic        stall;
    logic        flush;

    logic        ex_valid,  ex_valid2;
    logic [31:0] ex_pc,     ex_pc2;
    logic [4:0]  ex_rs,     ex_rs2;
    logic [4:0]  ex_rt,     ex_rt2;
    logic [4:0]  ex_rd,     ex_rd2;
    logic [31:0] ex_shamt,  ex_shamt2;
    logic [31:0] ex_imm,    ex_imm2;
    logic [31:0] ex_br_off, ex_br_off2;
    logic [31:0] ex_br_tgt, ex_br_tgt2;
    logic [15:0] ex_ctrl,   ex_ctrl2;
    logic [15:0] bubble_cnt;
    logic [1:0]  bubble_cnt2;

    id_ex_reg #(.CTRL_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_sext(id_sext), .id_ctrl(id_ctrl), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_shamt(ex_shamt), .ex_imm(ex_imm), .ex_br_off(ex_br_off), .ex_br_tgt(ex_br_tgt),
        .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt)
    );

    // Narrow counter instance to exercise saturation
    id_ex_reg #(.CTRL_W(16), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_sext(id_sext), .id_ctrl(id_ctrl), .stall(stall), .flush(flush),
        .ex_valid(ex_valid2), .ex_pc(ex_pc2), .ex_rs(ex_rs2), .ex_rt(ex_rt2), .ex_rd(ex_rd2),
        .ex_shamt(ex_shamt2), .ex_imm(ex_imm2), .ex_br_off(ex_br_off2), .ex_br_tgt(ex_br_tgt2),
        .ex_ctrl(ex_ctrl2), .bubble_cnt(bubble_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs, rt, rd;
        logic [31:0] shamt, imm, off, tgt;
        logic [15:0] ctrl;
    } exst_t;

    exst_t       m;
    int unsigned m_cnt;
    int unsigned m_cnt2;

    task automatic model_reset();
        m      = '{valid: 1'b0, pc: 0, rs: 0, rt: 0, rd: 0, shamt: 0, imm: 0, off: 0, tgt: 0, ctrl: 0};
        m_cnt  = 0;
        m_cnt2 = 0;
    endtask

    task automatic model_bubble();
        model_reset_fields();
        if (m_cnt  < 65535) m_cnt++;
        if (m_cnt2 < 3)     m_cnt2++;
    endtask

    task automatic model_reset_fields();
        m = '{valid: 1'b0, pc: 0, rs: 0, rt: 0, rd: 0, shamt: 0, imm: 0, off: 0, tgt: 0, ctrl: 0};
    endtask

    // One rising edge seen from the architectural rules
    task automatic model_step();
        int u16;
        int s16;
        if (flush || (!stall && !id_valid)) begin
            model_bubble();
        end else if (!stall) begin
            u16     = int'(id_instr & 32'hFFFF);
            s16     = (u16 >= 32768) ? u16 - 65536 : u16;
            m.valid = 1'b1;
            m.pc    = id_pc;
            m.rs    = 5'((id_instr >> 21) & 32'h1F);
            m.rt    = 5'((id_instr >> 16) & 32'h1F);
            m.rd    = 5'((id_instr >> 11) & 32'h1F);
            m.shamt = (id_instr >> 6) & 32'h1F;
            m.imm   = id_sext ? 32'(s16) : 32'(u16);
            m.off   = 32'(s16 * 4);
            m.tgt   = id_pc + 32'd4 + m.off;
            m.ctrl  = id_ctrl;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic sx, input logic [15:0] ctrl, input logic st, input logic fl);
        id_valid = v;
        id_instr = instr;
        id_pc    = pc;
        id_sext  = sx;
        id_ctrl  = ctrl;
        stall    = st;
        flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},  32'(ex_valid),  32'(m.valid));
        chk({tag, ".pc"},     ex_pc,          m.pc);
        chk({tag, ".rs"},     32'(ex_rs),     32'(m.rs));
        chk({tag, ".rt"},     32'(ex_rt),     32'(m.rt));
        chk({tag, ".rd"},     32'(ex_rd),     32'(m.rd));
        chk({tag, ".shamt"},  ex_shamt,       m.shamt);
        chk({tag, ".imm"},    ex_imm,         m.imm);
        chk({tag, ".broff"},  ex_br_off,      m.off);
        chk({tag, ".brtgt"},  ex_br_tgt,      m.tgt);
        chk({tag, ".ctrl"},   32'(ex_ctrl),   32'(m.ctrl));
        chk({tag, ".bubble"}, 32'(bubble_cnt), m_cnt);
        chk({tag, ".valid2"}, 32'(ex_valid2), 32'(m.valid));
        chk({tag, ".data2"},  ex_pc2 ^ ex_shamt2 ^ ex_imm2 ^ ex_br_off2 ^ ex_br_tgt2 ^
                              32'({ex_rs2, ex_rt2, ex_rd2}) ^ 32'(ex_ctrl2),
                              m.pc ^ m.shamt ^ m.imm ^ m.off ^ m.tgt ^
                              32'({m.rs, m.rt, m.rd}) ^ 32'(m.ctrl));
        chk({tag, ".bubble2"}, 32'(bubble_cnt2), m_cnt2);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        sext;
        logic [15:0] ctrl;
        logic [31:0] e_imm, e_off, e_tgt, e_shamt;
        logic [4:0]  e_rs, e_rt, e_rd;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic [15:0] cnt_save;
        logic [31:0] pc_save;

        tbl[0] = '{32'h2128FFFC, 32'h00400010, 1'b1, 16'hA5A5,
                   32'hFFFFFFFC, 32'hFFFFFFF0, 32'h00400004, 32'h0000001F, 5'd9, 5'd8, 5'd31};
        tbl[1] = '{32'h3508ABCD, 32'h00400014, 1'b0, 16'h1234,
                   32'h0000ABCD, 32'hFFFEAF34, 32'h003EAF4C, 32'h0000000F, 5'd8, 5'd8, 5'd21};
        tbl[2] = '{32'h00084140, 32'h00400018, 1'b1, 16'h0F0F,
                   32'h00004140, 32'h00010500, 32'h0041051C, 32'h00000005, 5'd0, 5'd8, 5'd8};
        tbl[3] = '{32'h20000000, 32'hFFFFFFFC, 1'b1, 16'hFFFF,
                   32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 5'd0, 5'd0, 5'd0};

        rst_n = 1'b0;
        drive(1'b1, 32'h2128FFFC, 32'h1234, 1'b1, 16'h5555, 1'b0, 1'b0);
        model_reset();
        #12;
        check_all("reset");
        #3 rst_n = 1'b1;

        // Directed loads
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, tbl[i].instr, tbl[i].pc, tbl[i].sext, tbl[i].ctrl, 1'b0, 1'b0);
            tick();
            chk($sformatf("tbl%0d.valid", i), 32'(ex_valid), 32'd1);
            chk($sformatf("tbl%0d.pc", i),    ex_pc,         tbl[i].pc);
            chk($sformatf("tbl%0d.imm", i),   ex_imm,        tbl[i].e_imm);
            chk($sformatf("tbl%0d.off", i),   ex_br_off,     tbl[i].e_off);
            chk($sformatf("tbl%0d.tgt", i),   ex_br_tgt,     tbl[i].e_tgt);
            chk($sformatf("tbl%0d.shamt", i), ex_shamt,      tbl[i].e_shamt);
            chk($sformatf("tbl%0d.rs", i),    32'(ex_rs),    32'(tbl[i].e_rs));
            chk($sformatf("tbl%0d.rt", i),    32'(ex_rt),    32'(tbl[i].e_rt));
            chk($sformatf("tbl%0d.rd", i),    32'(ex_rd),    32'(tbl[i].e_rd));
            chk($sformatf("tbl%0d.ctrl", i),  32'(ex_ctrl),  32'(tbl[i].ctrl));
            chk($sformatf("tbl%0d.bubble", i), 32'(bubble_cnt), 32'd0);
            check_all($sformatf("tbl%0d.model", i));
        end

        // Stall: 3 cycles with changing ID inputs, nothing moves
        drive(1'b1, 32'h2128FFFC, 32'h00400010, 1'b1, 16'hA5A5, 1'b0, 1'b0);
        tick();
        cnt_save = bubble_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, $urandom, 1'($urandom), 16'($urandom), 1'b1, 1'b0);
            tick();
            chk($sformatf("stall%0d.pc", i),     ex_pc,            32'h00400010);
            chk($sformatf("stall%0d.imm", i),    ex_imm,           32'hFFFFFFFC);
            chk($sformatf("stall%0d.bubble", i), 32'(bubble_cnt),  32'(cnt_save));
            check_all($sformatf("stall%0d", i));
        end
        drive(1'b1, 32'h3508ABCD, 32'h00400020, 1'b0, 16'h1234, 1'b0, 1'b0);
        tick();
        chk("stall_rel.pc",  ex_pc,  32'h00400020);
        chk("stall_rel.imm", ex_imm, 32'h0000ABCD);
        check_all("stall_rel");

        // Flush with simultaneous stall, then id_valid = 0 load
        cnt_save = bubble_cnt;
        drive(1'b1, 32'h2128FFFC, 32'h00400030, 1'b1, 16'hBEEF, 1'b1, 1'b1);
        tick();
        chk("flush_stall.valid",  32'(ex_valid),   32'd0);
        chk("flush_stall.ctrl",   32'(ex_ctrl),    32'd0);
        chk("flush_stall.bubble", 32'(bubble_cnt), 32'(cnt_save) + 32'd1);
        check_all("flush_stall");
        drive(1'b0, 32'h2128FFFC, 32'h00400034, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        tick();
        chk("idle.valid",  32'(ex_valid),   32'd0);
        chk("idle.bubble", 32'(bubble_cnt), 32'(cnt_save) + 32'd2);
        check_all("idle");

        // Saturation of the 2-bit counter: five flushes
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, $urandom, $urandom, 1'b1, 16'h7777, 1'($urandom), 1'b1);
            tick();
        end
        chk("sat.bubble2", 32'(bubble_cnt2), 32'd3);
        check_all("sat");
        drive(1'b1, 32'h00084140, 32'h00001000, 1'b0, 16'h0001, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h00084140, 32'h00001004, 1'b0, 16'h0001, 1'b0, 1'b1);
        tick();
        chk("sat_hold.bubble2", 32'(bubble_cnt2), 32'd3);

        // Asynchronous reset between edges
        drive(1'b1, 32'h2128FFFC, 32'h00400040, 1'b1, 16'hCAFE, 1'b0, 1'b0);
        tick();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.valid",  32'(ex_valid),    32'd0);
        chk("arst.bubble", 32'(bubble_cnt),  32'd0);
        check_all("arst");
        #2 rst_n = 1'b1;
        drive(1'b1, 32'h3508ABCD, 32'h00400050, 1'b0, 16'h4321, 1'b0, 1'b0);
        tick();
        chk("arst_rel.valid", 32'(ex_valid), 32'd1);
        chk("arst_rel.pc",    ex_pc,         32'h00400050);
        check_all("arst_rel");

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            pc_save = $urandom;
            drive(1'($urandom_range(0, 3) != 0), $urandom, pc_save, 1'($urandom),
                  16'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0));
            tick();
            check_all($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
